apb_master_bridge: RTL
======================

// Module: apb_master_bridge
// PURPOSE
//  - Upstream stage of the APB slave: converts a valid/ready request stream into APB3 transfers.
//  - Drives PSEL/PENABLE/PADDR/PWRITE/PWDATA and honours PREADY wait states (e.g. slave addrs 2, 3).
//  - Returns exactly one response (read data + error) per accepted request.
// PARAMETERS
//  - ADDR_W       3   APB address width
//  - DATA_W       16  APB read/write data width
//  - TIMEOUT_CYC  15  ACCESS cycles without PREADY before abort (used only with APB_TIMEOUT_EN)
// PORTS
//  - Pclk       in   1       single clock; all logic rising-edge
//  - Prst       in   1       reset, asynchronous, active-low
//  - req_valid  in   1       request present
//  - req_ready  out  1       request accepted when req_valid & req_ready
//  - req_write  in   1       1 = write, 0 = read
//  - req_addr   in   ADDR_W  transfer address
//  - req_wdata  in   DATA_W  write data (ignored on reads)
//  - rsp_valid  out  1       one-cycle pulse: transfer finished
//  - rsp_rdata  out  DATA_W  read data; 0 for writes and aborts
//  - rsp_err    out  1       PSLVERR sampled at completion, or timeout abort
//  - PSEL       out  1       APB select
//  - PENABLE    out  1       APB enable
//  - PADDR      out  ADDR_W  APB address
//  - PWRITE     out  1       APB direction
//  - PWDATA     out  DATA_W  APB write data
//  - PRDATA     in   DATA_W  APB read data
//  - PREADY     in   1       APB ready / wait-state control
//  - PSLVERR    in   1       APB slave error
// BEHAVIOUR
//  - Reset (Prst=0, async): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA = 0;
//    rsp_valid, rsp_rdata, rsp_err = 0. req_ready = 0 while reset is asserted.
//  - FSM states:
//    - IDLE: req_ready=1; on accept, register addr/write/wdata; next state SETUP.
//    - SETUP: PSEL=1, PENABLE=0; unconditionally go to ACCESS next cycle.
//    - ACCESS: PSEL=1, PENABLE=1; hold while PREADY=0 (PADDR/PWRITE/PWDATA stable).
//      - PREADY=1: transfer completes this cycle.
//  - Completion: next cycle, rsp_valid=1 for exactly one cycle.
//    - rsp_rdata = PRDATA if read, else 0.
//    - rsp_err = PSLVERR.
//  - Back-to-back: req_ready = IDLE | (ACCESS & PREADY).
//    - Accept in the completing cycle: next state SETUP directly, PSEL stays 1, PENABLE drops to 0.
//    - Otherwise: next state IDLE with PSEL=0.
//  - Latency: accept@t; SETUP@t+1; ACCESS@t+2.
//    - Zero-wait transfer: rsp_valid@t+3.
//    - Each wait cycle adds 1.
//  - No response backpressure: rsp_valid is not stallable; the consumer must sink every pulse.
//  - PADDR/PWDATA hold their last value in IDLE (not cleared); PWRITE as well.
//  - Reset mid-transfer: the transfer is dropped, no rsp_valid is issued, and the next request starts fresh.
// CONFIGURATION
//  - Macro APB_TIMEOUT_EN.
//  - Defined: cycle counter counts consecutive ACCESS cycles with PREADY=0.
//    - When count = TIMEOUT_CYC: abort with PSEL=PENABLE=0 next cycle, rsp_valid=1, rsp_err=1, rsp_rdata=0.
//    - After abort: state IDLE, counter cleared; counter also clears on every entry to SETUP.
//    - PREADY=1 in the same cycle the limit is reached: treat as normal completion (PREADY wins).
//  - Undefined: no counter logic; ACCESS waits indefinitely for PREADY.
// STRUCTURE
//  - Shared package apb_pkg:
//    - State encoding constants: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10.
//    - Default ADDR_W/DATA_W for the master, the slave and the top.
//  - Sub-module apb_timeout_ctr (counter + limit compare), instantiated only under APB_TIMEOUT_EN.
//  - Everything else is a single always block for the FSM plus output registers.
// TESTING
//  - No-wait read: addr=3'b000, slave PREADY=1, PRDATA=16'h0009
//    -> SETUP 1 cycle, ACCESS 1 cycle; rsp_valid@t+3, rsp_rdata=16'h0009, rsp_err=0.
//  - Wait write: addr=3'b011, wdata=16'h8009, PREADY low 2 ACCESS cycles
//    -> PWDATA stable throughout; rsp_valid@t+5, rsp_rdata=0.
//  - Back-to-back: req_valid held with write@1 then read@2
//    -> second SETUP immediately follows first completion; PSEL never drops; 2 rsp pulses.
//  - Slave error: read addr=3'b010 with PSLVERR=1 at PREADY -> rsp_err=1 for the single rsp pulse.
//  - Reset mid-ACCESS: Prst=0 during a wait
//    -> all outputs 0 immediately; no rsp_valid; a following read completes normally.
//  - APB_TIMEOUT_EN, TIMEOUT_CYC=15, PREADY stuck 0
//    -> abort after 15 ACCESS cycles, rsp_err=1, FSM in IDLE, req_ready=1.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
// Used by the master bridge, the APB slave and the top level.
package apb_pkg;

    localparam int APB_ADDR_W = 3;
    localparam int APB_DATA_W = 16;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SETUP  = 2'b01;
    localparam logic [1:0] ST_ACCESS = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SETUP  = ST_SETUP,
        ACCESS = ST_ACCESS
    } apb_state_e;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Counts consecutive stalled ACCESS cycles and flags the one that reaches the limit.
// Only compiled when APB_TIMEOUT_EN is defined.
`ifdef APB_TIMEOUT_EN
module apb_timeout_ctr #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_i,
    output logic hit_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // hit_o marks the TIMEOUT_CYC-th stalled cycle; the abort lands on the next edge.
    assign hit_o = count_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Anything other than a stall (SETUP, completion, abort) restarts the count.
    always_comb begin
        cnt_d = '0;
        if (count_i && !hit_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/apb_master_bridge.sv
// Valid/ready request stream to APB3 master, one response pulse per accepted request.
// Optional stall abort is enabled with the APB_TIMEOUT_EN macro.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              Pclk,
    input  logic              Prst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_e        state_q;
    logic              psel_q;
    logic              penable_q;
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              timeout_hit;
    logic              xfer_done;

`ifdef APB_TIMEOUT_EN
    apb_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_ctr (
        .clk     (Pclk),
        .rst_n   (Prst),
        .count_i ((state_q == ACCESS) && !PREADY),
        .hit_o   (timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
`endif

    assign xfer_done = (state_q == ACCESS) && PREADY;

    // Gated by Prst so no request is taken while reset is held.
    assign req_ready = Prst && ((state_q == IDLE) || xfer_done);

    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        paddr_q   <= req_addr;
                        pwrite_q  <= req_write;
                        pwdata_q  <= req_wdata;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
                        rsp_err_q   <= PSLVERR;
                        penable_q   <= 1'b0;
                        // A request waiting in the completing cycle skips IDLE; PSEL stays high.
                        if (req_valid) begin
                            paddr_q  <= req_addr;
                            pwrite_q <= req_write;
                            pwdata_q <= req_wdata;
                            state_q  <= SETUP;
                        end else begin
                            psel_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
